// File: rtl/iob_wstrb_split_ctrl_pkg.sv
// Shared types and width formulas for the IOb write-strobe splitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iob_wstrb_split_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    // Beat size codes (log2 of beat bytes).
    localparam int SZ_BYTE = 0;
    localparam int SZ_HALF = 1;
    localparam int SZ_WORD = 2;

    // Byte-offset width inside one word.
    function automatic int calc_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Width of the size code: must hold values 0..OFF_W.
    function automatic int calc_sz_w(input int data_w);
        return $clog2($clog2(data_w / 8) + 1);
    endfunction

endpackage

// File: rtl/iob_wstrb_split_ctrl_chunk.sv
// Residual strobe -> next beat (offset, size, lane mask); IOB_WSTRB_SPLIT_MERGE_EN enables aligned half/word merging.
// Latency: purely combinational.
// Backpressure: none; the owner holds the residual stable while a beat is stalled.
module iob_wstrb_chunk
    import iob_wstrb_split_ctrl_pkg::*;
#(
    parameter int NB    = 4,
    parameter int OFF_W = 2,
    parameter int SZ_W  = 2
) (
    input  logic [NB-1:0]    resid,
    output logic [OFF_W-1:0] offset,
    output logic [SZ_W-1:0]  size,
    output logic [NB-1:0]    mask
);

`ifdef IOB_WSTRB_SPLIT_MERGE_EN
    logic [NB-1:0] span_ones;
`endif

    // Lowest set lane starts the beat; optionally grow it to the largest aligned fully-set span.
    always_comb begin
        offset = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (resid[i]) offset = OFF_W'(i);
        end
        size = SZ_W'(SZ_BYTE);
        mask = NB'(1) << offset;
`ifdef IOB_WSTRB_SPLIT_MERGE_EN
        span_ones = '0;
        // Ascending k: the last span that qualifies is the largest one.
        for (int k = 1; k <= OFF_W; k++) begin
            span_ones = {NB{1'b1}} >> (NB - (1 << k));
            if (((int'(offset) % (1 << k)) == 0) &&
                (((resid >> offset) & span_ones) == span_ones)) begin
                size = SZ_W'(k);
                mask = span_ones << offset;
            end
        end
`endif
    end

endmodule

// File: rtl/iob_wstrb_split_ctrl.sv
// Splits one IOb word write into naturally aligned beats; reads pass as one word beat (macro IOB_WSTRB_SPLIT_MERGE_EN).
// Latency: accept at N, first m_valid at N+1, one beat per m_ready cycle, s_ack the cycle after the last beat.
// Backpressure: m_valid and beat fields held until m_ready; s_ready only in IDLE.
module iob_wstrb_split_ctrl
    import iob_wstrb_split_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = calc_off_w(DATA_W),
    localparam int SZ_W  = calc_sz_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [NB-1:0]     s_wstrb,
    output logic              s_ack,
    output logic [DATA_W-1:0] s_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [NB-1:0]     m_wstrb,
    output logic [SZ_W-1:0]   m_size,
    input  logic [DATA_W-1:0] m_rdata
);

    state_t                    state, state_nxt;
    logic [ADDR_W-OFF_W-1:0]   word_q;
    logic [DATA_W-1:0]         wdata_q;
    logic [DATA_W-1:0]         rdata_q;
    logic [NB-1:0]             resid_q;
    logic                      is_read_q;

    logic [OFF_W-1:0]          c_off;
    logic [SZ_W-1:0]           c_size;
    logic [NB-1:0]             c_mask;
    logic [NB-1:0]             resid_left;
    logic                      accept;
    logic                      beat_done;
    logic                      addr_lo_unused;

    // Byte offset of the slave address is ignored: requests are word aligned.
    assign addr_lo_unused = ^s_addr[OFF_W-1:0];

    iob_wstrb_chunk #(
        .NB    (NB),
        .OFF_W (OFF_W),
        .SZ_W  (SZ_W)
    ) u_chunk (
        .resid  (resid_q),
        .offset (c_off),
        .size   (c_size),
        .mask   (c_mask)
    );

    assign accept     = s_valid & s_ready;
    assign beat_done  = (state == ST_ISSUE) & m_ready;
    assign resid_left = resid_q & ~c_mask;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Request capture, residual strobe consumption and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resid_q   <= '0;
            is_read_q <= 1'b0;
        end else begin
            if (accept) begin
                word_q    <= s_addr[ADDR_W-1:OFF_W];
                wdata_q   <= s_wdata;
                resid_q   <= s_wstrb;
                is_read_q <= (s_wstrb == '0);
                rdata_q   <= '0;
            end
            if (beat_done) begin
                resid_q <= is_read_q ? '0 : resid_left;
                if (is_read_q) rdata_q <= m_rdata;
            end
        end
    end

    // Next-state: one beat per accepted handshake, ack after the residual empties.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE: if (beat_done && (is_read_q || (resid_left == '0))) state_nxt = ST_ACK;
            ST_ACK:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and beat field outputs; fields are zero outside ISSUE.
    always_comb begin
        s_ready = (state == ST_IDLE) & ~rst;
        s_ack   = (state == ST_ACK);
        m_valid = (state == ST_ISSUE);
        m_addr  = '0;
        m_wstrb = '0;
        m_size  = '0;
        if (state == ST_ISSUE) begin
            if (is_read_q) begin
                m_addr = {word_q, {OFF_W{1'b0}}};
                m_size = SZ_W'(OFF_W);
            end else begin
                m_addr  = {word_q, c_off};
                m_wstrb = c_mask;
                m_size  = c_size;
            end
        end
    end

    assign m_wdata = wdata_q;
    assign s_rdata = rdata_q;

endmodule

// File: tb/tb_iob_wstrb_split_ctrl.sv
// Directed bench for iob_wstrb_split_ctrl (DATA_W=32); expected beats are queued per request.
// Latency: checks first beat one cycle after accept and s_ack one cycle after the last beat.
// Backpressure: stalls m_ready per beat and holds s_valid outside IDLE.
module tb_iob_wstrb_split_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int NB     = DATA_W / 8;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic [NB-1:0]     strb;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [NB-1:0]     s_wstrb;
    logic              s_ack;
    logic [DATA_W-1:0] s_rdata;
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [NB-1:0]     m_wstrb;
    logic [1:0]        m_size;
    logic [DATA_W-1:0] m_rdata;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] exp_wdata;
    int                n_checks = 0;
    int                n_fail   = 0;

    iob_wstrb_split_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_ack   (s_ack),
        .s_rdata (s_rdata),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_size  (m_size),
        .m_rdata (m_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [1:0] sz, input logic [NB-1:0] st);
        beat_t b;
        b.addr = a;
        b.size = sz;
        b.strb = st;
        exp_q.push_back(b);
    endtask

    // Drive a request at posedge+1, confirm s_ready, let it be accepted.
    task automatic do_request(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [NB-1:0] st, input bit keep);
        s_valid   = 1'b1;
        s_addr    = a;
        s_wdata   = d;
        s_wstrb   = st;
        exp_wdata = d;
        @(negedge clk);
        check("s_ready_idle", s_ready, 1);
        check("s_ack_idle", s_ack, 0);
        @(posedge clk);
        #1;
        if (!keep) s_valid = 1'b0;
    endtask

    // Stall a beat for 'stall' cycles, then accept it; fields must match the queue head throughout.
    task automatic serve_one(input int stall, input logic [DATA_W-1:0] rd);
        beat_t b;
        if (exp_q.size() == 0) begin
            check("beat_queue_nonempty", 0, 1);
            return;
        end
        b = exp_q[0];
        for (int c = 0; c <= stall; c++) begin
            m_ready = (c == stall);
            m_rdata = rd;
            @(negedge clk);
            check("m_valid", m_valid, 1);
            check("m_addr", m_addr, b.addr);
            check("m_size", m_size, b.size);
            check("m_wstrb", m_wstrb, b.strb);
            check("m_wdata", m_wdata, exp_wdata);
            check("s_ready_busy", s_ready, 0);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b0;
        void'(exp_q.pop_front());
    endtask

    task automatic serve_all(input int stall, input logic [DATA_W-1:0] rd);
        while (exp_q.size() != 0) serve_one(stall, rd);
    endtask

    task automatic check_ack(input bit is_rd, input logic [DATA_W-1:0] rd);
        @(negedge clk);
        check("s_ack", s_ack, 1);
        check("m_valid_in_ack", m_valid, 0);
        check("s_ready_in_ack", s_ready, 0);
        if (is_rd) check("s_rdata", s_rdata, rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
        m_ready = 1'b0; m_rdata = '0; exp_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_s_ack", s_ack, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_m_wstrb", m_wstrb, 0);
        check("rst_m_size", m_size, 0);
        check("rst_s_rdata", s_rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full word write.
`ifdef IOB_WSTRB_SPLIT_MERGE_EN
        push(32'h100, 2, 4'b1111);
`else
        push(32'h100, 0, 4'b0001); push(32'h101, 0, 4'b0010);
        push(32'h102, 0, 4'b0100); push(32'h103, 0, 4'b1000);
`endif
        do_request(32'h100, 32'hA1B2_C3D4, 4'b1111, 0);
        serve_all(0, 32'h0);
        check_ack(0, 32'h0);

        // 1110: odd start lane.
`ifdef IOB_WSTRB_SPLIT_MERGE_EN
        push(32'h101, 0, 4'b0010); push(32'h102, 1, 4'b1100);
`else
        push(32'h101, 0, 4'b0010); push(32'h102, 0, 4'b0100); push(32'h103, 0, 4'b1000);
`endif
        do_request(32'h100, 32'h1122_3344, 4'b1110, 0);
        serve_all(0, 32'h0);
        check_ack(0, 32'h0);

        // Read: one word beat, rdata returned with ack.
        push(32'h100, 2, 4'b0000);
        do_request(32'h100, 32'h5555_AAAA, 4'b0000, 0);
        serve_all(0, 32'hDEAD_BEEF);
        check_ack(1, 32'hDEAD_BEEF);

        // 0101 with 3 stall cycles per beat.
        push(32'h100, 0, 4'b0001); push(32'h102, 0, 4'b0100);
        do_request(32'h100, 32'hCAFE_F00D, 4'b0101, 0);
        serve_all(3, 32'h0);
        check_ack(0, 32'h0);

        // 1011 at 0x104: merged half at the bottom then a lone byte.
`ifdef IOB_WSTRB_SPLIT_MERGE_EN
        push(32'h104, 1, 4'b0011); push(32'h107, 0, 4'b1000);
`else
        push(32'h104, 0, 4'b0001); push(32'h105, 0, 4'b0010); push(32'h107, 0, 4'b1000);
`endif
        do_request(32'h104, 32'h0BAD_CAFE, 4'b1011, 0);
        serve_all(1, 32'h0);
        check_ack(0, 32'h0);

        // s_valid held through a transaction: the second request waits for IDLE.
`ifdef IOB_WSTRB_SPLIT_MERGE_EN
        push(32'h100, 1, 4'b0011);
`else
        push(32'h100, 0, 4'b0001); push(32'h101, 0, 4'b0010);
`endif
        do_request(32'h100, 32'h1234_5678, 4'b0011, 1);
        s_addr = 32'h200; s_wdata = 32'h8765_4321; s_wstrb = 4'b1100;
        serve_all(1, 32'h0);
        check_ack(0, 32'h0);
`ifdef IOB_WSTRB_SPLIT_MERGE_EN
        push(32'h200, 1, 4'b1100);
`else
        push(32'h202, 0, 4'b0100); push(32'h203, 0, 4'b1000);
`endif
        do_request(32'h200, 32'h8765_4321, 4'b1100, 0);
        serve_all(0, 32'h0);
        check_ack(0, 32'h0);

        // Reset after the first of two beats: abort, no ack.
        push(32'h100, 0, 4'b0001); push(32'h102, 0, 4'b0100);
        do_request(32'h100, 32'h7777_8888, 4'b0101, 0);
        serve_one(0, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_m_valid", m_valid, 0);
        check("abort_s_ack", s_ack, 0);
        check("abort_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_no_late_ack", s_ack, 0);
        check("abort_idle_m_valid", m_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
